// File: rtl/adc_scan_seq_if.sv
// ADC scan sequencer bus.
// Groups the two handshakes of the sequencer onto one bundle:
//   - ADC controller side: ctrl (start pulse), n (channel select),
//     ready (conversion-done level), data (12-bit conversion result).
//   - Sample consumer side: out_data, out_ch, out_valid, out_ready.
// master: the sequencer (drives ctrl/n/out_*, receives ready/data/out_ready).
// slave : the environment (ADC controller plus consumer).
interface adc_scan_seq_if;
    logic        ctrl;
    logic        n;
    logic        ready;
    logic [11:0] data;
    logic [11:0] out_data;
    logic        out_ch;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output ctrl, n, out_data, out_ch, out_valid,
        input  ready, data, out_ready
    );

    modport slave (
        input  ctrl, n, out_data, out_ch, out_valid,
        output ready, data, out_ready
    );
endinterface

// File: rtl/adc_scan_seq.sv
// Periodic two-channel ADC scan sequencer.
// Every max(period,1) enabled cycles a scan tick fires. A tick in IDLE
// walks the channels set in ch_mask (ascending): for each one it pulses
// ctrl for CTRL_W cycles with n = channel, waits for a rising edge on
// ready (bounded by TIMEOUT cycles), and presents the result on a
// valid/ready output register.
// Ports:
//   clk_in, rst          clock, asynchronous active-high reset
//   enable, period       tick generator control
//   ch_mask              channels included in each scan (sampled at the tick)
//   clr                  clears the sticky error flags
//   bus (master)         ADC controller and sample consumer handshakes
//   busy                 scan in progress
//   overrun, late, timeout_err  sticky error flags
module adc_scan_seq #(
    parameter int CTRL_W  = 2,
    parameter int TIMEOUT = 128,
    parameter int PER_W   = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    input  logic [1:0]       ch_mask,
    input  logic             clr,
    adc_scan_seq_if.master   bus,
    output logic             busy,
    output logic             overrun,
    output logic             late,
    output logic             timeout_err
);
    // One step counter serves both the START pulse width and the CONV timeout.
    localparam int CW = $clog2(CTRL_W + TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, CONV, STORE} state_t;

    state_t           state_reg, state_next;
    logic [PER_W-1:0] tick_cnt_reg, tick_cnt_next, per_eff;
    logic             tick;
    logic [CW-1:0]    step_cnt_reg, step_cnt_next;
    logic             ch_reg, ch_next;
    logic             pend_reg, pend_next;   // channel 1 still to do in this scan
    logic             ready_q_reg;
    logic             complete, timed_out;
    logic [11:0]      out_data_reg;
    logic             out_ch_reg, out_valid_reg;
    logic             overrun_reg, late_reg, timeout_reg;

    // Tick generator: a period of 0 behaves like 1 (tick every cycle).
    always_comb begin
        per_eff       = (period == '0) ? PER_W'(1) : period;
        tick          = enable && (tick_cnt_reg == per_eff - PER_W'(1));
        tick_cnt_next = (!enable || tick) ? '0 : tick_cnt_reg + PER_W'(1);
    end

    // Next-state logic.
    always_comb begin
        state_next    = state_reg;
        step_cnt_next = step_cnt_reg + CW'(1);
        ch_next       = ch_reg;
        pend_next     = pend_reg;
        complete      = 1'b0;
        timed_out     = 1'b0;
        case (state_reg)
            IDLE: begin
                step_cnt_next = '0;
                if (tick && ch_mask != 2'b00) begin
                    state_next = START;
                    ch_next    = ~ch_mask[0];   // lowest set channel
                    pend_next  = &ch_mask;      // ch1 follows only if ch0 went first
                end
            end
            START: begin
                if (step_cnt_reg == CW'(CTRL_W - 1)) begin
                    state_next    = CONV;
                    step_cnt_next = '0;
                end
            end
            CONV: begin
                // Only a fresh rising edge counts; a level already high on
                // entry is a leftover from a previous conversion.
                if (bus.ready && !ready_q_reg) begin
                    complete      = 1'b1;
                    state_next    = STORE;
                    step_cnt_next = '0;
                end else if (step_cnt_reg == CW'(TIMEOUT - 1)) begin
                    timed_out     = 1'b1;
                    step_cnt_next = '0;
                    if (pend_reg) begin
                        state_next = START;
                        ch_next    = 1'b1;
                        pend_next  = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            STORE: begin
                step_cnt_next = '0;
                if (pend_reg) begin
                    state_next = START;
                    ch_next    = 1'b1;
                    pend_next  = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            step_cnt_reg  <= '0;
            ch_reg        <= 1'b0;
            pend_reg      <= 1'b0;
            ready_q_reg   <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            late_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            step_cnt_reg <= step_cnt_next;
            ch_reg       <= ch_next;
            pend_reg     <= pend_next;
            ready_q_reg  <= bus.ready;

            // A capture takes priority over acceptance so a sample landing in
            // the same cycle as the handshake keeps out_valid high.
            if (complete) begin
                out_data_reg  <= bus.data;
                out_ch_reg    <= ch_reg;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end

            // Sticky flags: a setting event wins over clr.
            if (complete && out_valid_reg && !bus.out_ready)
                overrun_reg <= 1'b1;
            else if (clr)
                overrun_reg <= 1'b0;

            if (tick && state_reg != IDLE)
                late_reg <= 1'b1;
            else if (clr)
                late_reg <= 1'b0;

            if (timed_out)
                timeout_reg <= 1'b1;
            else if (clr)
                timeout_reg <= 1'b0;
        end
    end

    assign bus.ctrl      = (state_reg == START);
    assign bus.n         = ch_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.out_valid = out_valid_reg;
    assign busy          = (state_reg != IDLE);
    assign overrun       = overrun_reg;
    assign late          = late_reg;
    assign timeout_err   = timeout_reg;
endmodule

// File: tb/tb_adc_scan_seq.sv
module tb_adc_scan_seq;
    localparam int S_CTRL  = 0;
    localparam int S_VALID = 1;
    localparam int S_TMO   = 2;
    localparam int S_BUSY  = 3;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] period = 16'd200;
    logic [1:0]  ch_mask = 2'b01;
    logic        busy, overrun, late, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    adc_scan_seq_if bus();

    adc_scan_seq #(.CTRL_W(2), .TIMEOUT(128), .PER_W(16)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .ch_mask     (ch_mask),
        .clr         (clr),
        .bus         (bus.master),
        .busy        (busy),
        .overrun     (overrun),
        .late        (late),
        .timeout_err (timeout_err)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    // ADC controller model: raises ready adc_delay cycles after ctrl falls,
    // with the value assigned to the selected channel, holds it 2 cycles.
    bit          adc_en = 1'b1;
    int          adc_delay = 40;
    logic [11:0] adc_vals [2];
    int          adc_cnt = 0;
    bit          adc_armed = 1'b0;
    int          hold_cnt = 0;
    logic        ctrl_prev = 1'b0;

    always @(negedge clk_in) begin
        if (rst) begin
            bus.ready = 1'b0;
            bus.data  = '0;
            adc_armed = 1'b0;
            hold_cnt  = 0;
        end else begin
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) bus.ready = 1'b0;
            end
            if (ctrl_prev && !bus.ctrl) begin
                if (adc_en) begin
                    adc_armed = 1'b1;
                    adc_cnt   = adc_delay;
                end
            end else if (adc_armed) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    adc_armed = 1'b0;
                    bus.ready = 1'b1;
                    bus.data  = adc_vals[bus.n];
                    hold_cnt  = 2;
                end
            end
        end
        ctrl_prev = bus.ctrl;
    end

    task automatic wait_until(input int sel, input logic val, input int limit, output bit ok);
        logic s;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_in);
            case (sel)
                S_CTRL:  s = bus.ctrl;
                S_VALID: s = bus.out_valid;
                S_TMO:   s = timeout_err;
                default: s = busy;
            endcase
            if (s === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b1;
        enable = 1'b0;
        clr = 1'b0;
        bus.out_ready = 1'b1;
        adc_en = 1'b1;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        bit seen;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        flags = {bus.ctrl, bus.n, busy, bus.out_valid, bus.out_ch, overrun, late, timeout_err};
        checks++;
        if (flags !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got=%b want=00000000", flags);
        end
        checks++;
        if (bus.out_data !== 12'h000) begin
            errors++;
            $display("FAIL reset_out_data got=%h want=000", bus.out_data);
        end
        // Held in reset, an enabled fast tick must not start anything.
        period = 16'd1;
        ch_mask = 2'b01;
        enable = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk_in);
            seen |= (bus.ctrl | busy);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got=%b want=0", seen);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        bit ok;
        int c0, crise, cfall;
        do_reset();
        period = 16'd200;
        ch_mask = 2'b01;
        adc_delay = 40;
        adc_vals[0] = 12'hABC;
        bus.out_ready = 1'b1;
        enable = 1'b1;
        c0 = cyc;
        wait_until(S_CTRL, 1'b1, 400, ok);
        crise = cyc;
        checks++;
        if (!ok || crise - c0 != 200) begin
            errors++;
            $display("FAIL single_first_tick got=%0d want=200", crise - c0);
        end
        checks++;
        if (bus.n !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_start got n=%b busy=%b want n=0 busy=1", bus.n, busy);
        end
        wait_until(S_CTRL, 1'b0, 10, ok);
        cfall = cyc;
        checks++;
        if (!ok || cfall - crise != 2) begin
            errors++;
            $display("FAIL single_ctrl_width got=%0d want=2", cfall - crise);
        end
        wait_until(S_VALID, 1'b1, 100, ok);
        checks++;
        if (!ok || cyc - cfall != 41) begin
            errors++;
            $display("FAIL single_valid_latency got=%0d want=41", cyc - cfall);
        end
        checks++;
        if ({bus.out_ch, bus.out_data} !== {1'b0, 12'hABC}) begin
            errors++;
            $display("FAIL single_sample got ch=%b data=%h want ch=0 data=abc", bus.out_ch, bus.out_data);
        end
        @(negedge clk_in);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_valid_width got=%b want=0", bus.out_valid);
        end
        wait_until(S_CTRL, 1'b1, 300, ok);
        checks++;
        if (!ok || cyc - crise != 200) begin
            errors++;
            $display("FAIL single_repeat got=%0d want=200", cyc - crise);
        end
        wait_until(S_VALID, 1'b1, 100, ok);
        checks++;
        if (!ok || bus.out_data !== 12'hABC) begin
            errors++;
            $display("FAIL single_second_sample got=%h want=abc", bus.out_data);
        end
        enable = 1'b0;
        $display("test_single done");
    endtask

    task automatic test_two_channel();
        bit ok;
        do_reset();
        period = 16'd50;
        ch_mask = 2'b11;
        adc_delay = 10;
        adc_vals[0] = 12'h111;
        adc_vals[1] = 12'h222;
        bus.out_ready = 1'b1;
        enable = 1'b1;
        wait_until(S_CTRL, 1'b1, 100, ok);
        checks++;
        if (!ok || bus.n !== 1'b0) begin
            errors++;
            $display("FAIL two_first_n got=%b want=0", bus.n);
        end
        wait_until(S_VALID, 1'b1, 60, ok);
        checks++;
        if (!ok || {bus.out_ch, bus.out_data} !== {1'b0, 12'h111}) begin
            errors++;
            $display("FAIL two_sample0 got ch=%b data=%h want ch=0 data=111", bus.out_ch, bus.out_data);
        end
        wait_until(S_CTRL, 1'b1, 5, ok);
        checks++;
        if (!ok || bus.n !== 1'b1) begin
            errors++;
            $display("FAIL two_second_n got=%b want=1", bus.n);
        end
        wait_until(S_VALID, 1'b1, 60, ok);
        checks++;
        if (!ok || {bus.out_ch, bus.out_data} !== {1'b1, 12'h222}) begin
            errors++;
            $display("FAIL two_sample1 got ch=%b data=%h want ch=1 data=222", bus.out_ch, bus.out_data);
        end
        wait_until(S_BUSY, 1'b0, 5, ok);
        checks++;
        if (!ok || overrun !== 1'b0) begin
            errors++;
            $display("FAIL two_end got ok=%b overrun=%b want ok=1 overrun=0", ok, overrun);
        end
        enable = 1'b0;
        $display("test_two_channel done");
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        period = 16'd50;
        ch_mask = 2'b11;
        adc_delay = 10;
        adc_vals[0] = 12'h111;
        adc_vals[1] = 12'h222;
        bus.out_ready = 1'b0;
        enable = 1'b1;
        wait_until(S_VALID, 1'b1, 150, ok);
        checks++;
        if (!ok || {bus.out_ch, bus.out_data} !== {1'b0, 12'h111} || overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_first got ch=%b data=%h ovr=%b want ch=0 data=111 ovr=0", bus.out_ch, bus.out_data, overrun);
        end
        wait_until(S_BUSY, 1'b0, 60, ok);
        enable = 1'b0;
        checks++;
        if (!ok || {bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, 1'b1, 12'h222}) begin
            errors++;
            $display("FAIL bp_overwrite got v=%b ch=%b data=%h want v=1 ch=1 data=222", bus.out_valid, bus.out_ch, bus.out_data);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_overrun got=%b want=1", overrun);
        end
        @(negedge clk_in);
        clr = 1'b1;
        @(negedge clk_in);
        clr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 12'h222) begin
            errors++;
            $display("FAIL bp_clr got ovr=%b v=%b data=%h want ovr=0 v=1 data=222", overrun, bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        @(negedge clk_in);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept got=%b want=0", bus.out_valid);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_timeout();
        bit ok;
        int c1;
        do_reset();
        period = 16'd300;
        ch_mask = 2'b01;
        adc_en = 1'b0;
        bus.out_ready = 1'b1;
        enable = 1'b1;
        wait_until(S_CTRL, 1'b1, 400, ok);
        wait_until(S_CTRL, 1'b0, 10, ok);
        c1 = cyc;
        wait_until(S_TMO, 1'b1, 200, ok);
        checks++;
        if (!ok || cyc - c1 != 128) begin
            errors++;
            $display("FAIL tmo_delay got=%0d want=128", cyc - c1);
        end
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_idle got busy=%b v=%b want busy=0 v=0", busy, bus.out_valid);
        end
        enable = 1'b0;
        clr = 1'b1;
        @(negedge clk_in);
        clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clr got=%b want=0", timeout_err);
        end
        adc_en = 1'b1;
        $display("test_timeout done");
    endtask

    task automatic test_late();
        bit ok;
        do_reset();
        period = 16'd20;
        ch_mask = 2'b01;
        adc_delay = 40;
        adc_vals[0] = 12'h3C3;
        bus.out_ready = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_until(S_VALID, 1'b1, 200, ok);
            checks++;
            if (!ok || bus.out_data !== 12'h3C3) begin
                errors++;
                $display("FAIL late_scan%0d got ok=%b data=%h want ok=1 data=3c3", k, ok, bus.out_data);
            end
        end
        checks++;
        if (late !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL late_flag got late=%b tmo=%b want late=1 tmo=0", late, timeout_err);
        end
        enable = 1'b0;
        wait_until(S_BUSY, 1'b0, 100, ok);
        $display("test_late done");
    endtask

    task automatic test_period_zero();
        bit ok;
        bit seen;
        do_reset();
        period = 16'd0;
        ch_mask = 2'b00;
        adc_delay = 5;
        adc_vals[0] = 12'h0F0;
        bus.out_ready = 1'b1;
        enable = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk_in);
            seen |= (busy | bus.ctrl);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL p0_empty_mask got=%b want=0", seen);
        end
        ch_mask = 2'b01;
        @(negedge clk_in);
        checks++;
        if (bus.ctrl !== 1'b1) begin
            errors++;
            $display("FAIL p0_start got=%b want=1", bus.ctrl);
        end
        repeat (2) @(negedge clk_in);
        checks++;
        if (late !== 1'b1) begin
            errors++;
            $display("FAIL p0_late got=%b want=1", late);
        end
        enable = 1'b0;
        wait_until(S_VALID, 1'b1, 30, ok);
        checks++;
        if (!ok || bus.out_data !== 12'h0F0) begin
            errors++;
            $display("FAIL p0_finish got ok=%b data=%h want ok=1 data=0f0", ok, bus.out_data);
        end
        wait_until(S_BUSY, 1'b0, 10, ok);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk_in);
            seen |= (busy | bus.ctrl);
        end
        checks++;
        if (!ok || seen !== 1'b0) begin
            errors++;
            $display("FAIL p0_disabled got ok=%b seen=%b want ok=1 seen=0", ok, seen);
        end
        $display("test_period_zero done");
    endtask

    task automatic test_reset_mid_conv();
        bit ok;
        int c0;
        logic [19:0] outs;
        do_reset();
        period = 16'd60;
        ch_mask = 2'b10;
        adc_delay = 10;
        adc_vals[1] = 12'h5A5;
        bus.out_ready = 1'b0;
        enable = 1'b1;
        wait_until(S_VALID, 1'b1, 150, ok);
        checks++;
        if (!ok || {bus.out_ch, bus.out_data} !== {1'b1, 12'h5A5}) begin
            errors++;
            $display("FAIL rmc_sample got ch=%b data=%h want ch=1 data=5a5", bus.out_ch, bus.out_data);
        end
        wait_until(S_CTRL, 1'b1, 100, ok);
        wait_until(S_CTRL, 1'b0, 5, ok);
        checks++;
        if (!ok || bus.n !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmc_in_conv got n=%b busy=%b want n=1 busy=1", bus.n, busy);
        end
        #2 rst = 1'b1;
        #1;
        outs = {bus.ctrl, bus.n, busy, bus.out_valid, bus.out_ch, overrun, late, timeout_err, bus.out_data};
        checks++;
        if (outs !== 20'h00000) begin
            errors++;
            $display("FAIL rmc_async_clear got=%h want=00000", outs);
        end
        @(negedge clk_in);
        rst = 1'b0;
        c0 = cyc;
        wait_until(S_CTRL, 1'b1, 100, ok);
        checks++;
        if (!ok || cyc - c0 != 60) begin
            errors++;
            $display("FAIL rmc_restart got=%0d want=60", cyc - c0);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rmc_no_side_effect got v=%b tmo=%b want v=0 tmo=0", bus.out_valid, timeout_err);
        end
        enable = 1'b0;
        $display("test_reset_mid_conv done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_channel();
        test_backpressure();
        test_timeout();
        test_late();
        test_period_zero();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
